pl_ddr_rd_ctrl: RTL and testbench

Parametrised PL-side DDR3 read controller. It sits between user logic and a Xilinx AXI DataMover MM2S channel. A single read request of any length is split into DataMover commands of at most CHUNK_BYTES each. Read beats are returned on a valid/ready stream with backpressure, an end-of-transfer marker, completion and error reporting.

---
 rtl/pl_ddr_rd_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_pl_ddr_rd_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_ddr_rd_ctrl.sv
// Splits one byte-length DDR read into AXI DataMover MM2S commands of at most
// CHUNK_BYTES and streams the beats out through a one-deep output register.
// Optional feature macro: RD_STS_CHECK_EN (status channel decoding).
module pl_ddr_rd_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int CHUNK_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ddr_init_done,
  input  logic                  rd_start,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [31:0]           rd_len,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_last,
  output logic                  s_axis_mm2s_cmd_tvalid,
  input  logic                  s_axis_mm2s_cmd_tready,
  output logic [ADDR_W+39:0]    s_axis_mm2s_cmd_tdata,
  input  logic                  m_axis_mm2s_tvalid,
  output logic                  m_axis_mm2s_tready,
  input  logic                  m_axis_mm2s_tlast,
  input  logic [DATA_W-1:0]     m_axis_mm2s_tdata,
  input  logic [DATA_W/8-1:0]   m_axis_mm2s_tkeep,
  input  logic                  m_axis_mm2s_sts_tvalid,
  output logic                  m_axis_mm2s_sts_tready,
  input  logic [7:0]            m_axis_mm2s_sts_tdata
);

  localparam int CMD_W = ADDR_W + 40;
  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam logic [31:0] CHUNK_L  = 32'(CHUNK_BYTES);
  localparam logic [31:0] LEN_MASK = ~(32'(BYTES) - 32'd1);

  typedef enum logic [2:0] {
    S_WAIT_INIT = 3'd0,
    S_IDLE      = 3'd1,
    S_CMD       = 3'd2,
    S_DATA      = 3'd3,
    S_STS       = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t             state_r;
  logic               start_d_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [31:0]        rem_r;
  logic [22:0]        btt_r;
  logic [22:0]        beat_cnt_r;
  logic [3:0]         tag_r;
  logic               rd_busy_r;
  logic               rd_done_r;
  logic               rd_err_r;
  logic               cmd_tvalid_r;
  logic [CMD_W-1:0]   cmd_tdata_r;
  logic               rd_valid_r;
  logic [DATA_W-1:0]  rd_data_r;
  logic               rd_last_r;

  logic               start_edge_s;
  logic [31:0]        len_masked_s;
  logic               m_tready_s;
  logic               beat_acc_s;
  logic [22:0]        exp_beats_s;
  logic               mismatch_s;
  logic               err_now_s;
  logic [ADDR_W-1:0]  addr_nxt_s;
  logic [31:0]        rem_nxt_s;
  logic               unused_s;

  function automatic logic [22:0] calc_btt(input logic [31:0] rem);
    logic [31:0] b;
    if (rem > CHUNK_L) b = CHUNK_L;
    else               b = rem;
    return b[22:0];
  endfunction

  function automatic logic [CMD_W-1:0] build_cmd(input logic [ADDR_W-1:0] addr,
                                                 input logic [31:0] rem,
                                                 input logic [3:0] tag);
    return {4'b0000, tag, addr, 1'b0, (rem <= CHUNK_L), 6'b000000, 1'b1, calc_btt(rem)};
  endfunction

  assign start_edge_s = rd_start & ~start_d_r;
  assign len_masked_s = rd_len & LEN_MASK;
  assign m_tready_s   = ~rd_valid_r | rd_ready;
  assign beat_acc_s   = (state_r == S_DATA) & m_axis_mm2s_tvalid & m_tready_s;
  assign exp_beats_s  = btt_r >> LSB;
  assign mismatch_s   = m_axis_mm2s_tlast & (beat_cnt_r != (exp_beats_s - 23'd1));
  assign err_now_s    = rd_err_r | mismatch_s;
  assign addr_nxt_s   = addr_r + ADDR_W'(btt_r);
  assign rem_nxt_s    = rem_r - {9'd0, btt_r};

`ifdef RD_STS_CHECK_EN
  logic sts_tready_r;
  logic sts_bad_s;
  assign sts_bad_s              = ~m_axis_mm2s_sts_tdata[7] | (|m_axis_mm2s_sts_tdata[6:4]);
  assign m_axis_mm2s_sts_tready = sts_tready_r;
  assign unused_s               = ^m_axis_mm2s_tkeep;
`else
  assign m_axis_mm2s_sts_tready = 1'b1;
  assign unused_s               = ^{m_axis_mm2s_tkeep, m_axis_mm2s_sts_tvalid, m_axis_mm2s_sts_tdata};
`endif

  // Transfer sequencing: request latch, command generation, chunk bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_WAIT_INIT;
      start_d_r    <= 1'b0;
      addr_r       <= '0;
      rem_r        <= 32'd0;
      btt_r        <= 23'd0;
      beat_cnt_r   <= 23'd0;
      tag_r        <= 4'd0;
      rd_busy_r    <= 1'b0;
      rd_done_r    <= 1'b0;
      rd_err_r     <= 1'b0;
      cmd_tvalid_r <= 1'b0;
      cmd_tdata_r  <= '0;
`ifdef RD_STS_CHECK_EN
      sts_tready_r <= 1'b0;
`endif
    end else begin
      start_d_r <= rd_start;
      rd_done_r <= 1'b0;
      case (state_r)
        S_WAIT_INIT: begin
          if (ddr_init_done) state_r <= S_IDLE;
        end
        S_IDLE: begin
          if (start_edge_s) begin
            addr_r     <= rd_addr;
            rem_r      <= len_masked_s;
            rd_err_r   <= 1'b0;
            beat_cnt_r <= 23'd0;
            tag_r      <= 4'd0;
            rd_busy_r  <= 1'b1;
            if (len_masked_s == 32'd0) begin
              state_r <= S_DONE;
            end else begin
              state_r      <= S_CMD;
              cmd_tvalid_r <= 1'b1;
              cmd_tdata_r  <= build_cmd(rd_addr, len_masked_s, 4'd0);
              btt_r        <= calc_btt(len_masked_s);
            end
          end
        end
        S_CMD: begin
          if (s_axis_mm2s_cmd_tready) begin
            cmd_tvalid_r <= 1'b0;
            beat_cnt_r   <= 23'd0;
            state_r      <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_acc_s) begin
            beat_cnt_r <= beat_cnt_r + 23'd1;
            if (m_axis_mm2s_tlast) begin
              addr_r <= addr_nxt_s;
              rem_r  <= rem_nxt_s;
              if (mismatch_s) rd_err_r <= 1'b1;
`ifdef RD_STS_CHECK_EN
              state_r      <= S_STS;
              sts_tready_r <= 1'b1;
`else
              if (err_now_s || (rem_nxt_s == 32'd0)) begin
                state_r <= S_DONE;
              end else begin
                state_r      <= S_CMD;
                cmd_tvalid_r <= 1'b1;
                cmd_tdata_r  <= build_cmd(addr_nxt_s, rem_nxt_s, tag_r + 4'd1);
                tag_r        <= tag_r + 4'd1;
                btt_r        <= calc_btt(rem_nxt_s);
              end
`endif
            end
          end
        end
`ifdef RD_STS_CHECK_EN
        S_STS: begin
          if (m_axis_mm2s_sts_tvalid) begin
            sts_tready_r <= 1'b0;
            if (sts_bad_s) rd_err_r <= 1'b1;
            if (rd_err_r || sts_bad_s || (rem_r == 32'd0)) begin
              state_r <= S_DONE;
            end else begin
              state_r      <= S_CMD;
              cmd_tvalid_r <= 1'b1;
              cmd_tdata_r  <= build_cmd(addr_r, rem_r, tag_r + 4'd1);
              tag_r        <= tag_r + 4'd1;
              btt_r        <= calc_btt(rem_r);
            end
          end
        end
`endif
        S_DONE: begin
          rd_done_r <= 1'b1;
          rd_busy_r <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          state_r <= S_WAIT_INIT;
        end
      endcase
    end
  end

  // One-deep output register; rd_last also closes the stream on an aborted chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
      rd_last_r  <= 1'b0;
    end else if (beat_acc_s) begin
      rd_valid_r <= 1'b1;
      rd_data_r  <= m_axis_mm2s_tdata;
      rd_last_r  <= m_axis_mm2s_tlast & ((rem_nxt_s == 32'd0) | err_now_s);
    end else if (rd_ready) begin
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_valid_r;
      rd_last_r  <= rd_last_r;
    end
  end

  assign rd_busy                = rd_busy_r;
  assign rd_done                = rd_done_r;
  assign rd_err                 = rd_err_r;
  assign rd_valid               = rd_valid_r;
  assign rd_data                = rd_data_r;
  assign rd_last                = rd_last_r;
  assign s_axis_mm2s_cmd_tvalid = cmd_tvalid_r;
  assign s_axis_mm2s_cmd_tdata  = cmd_tdata_r;
  assign m_axis_mm2s_tready     = m_tready_s;

endmodule

// File: tb/tb_pl_ddr_rd_ctrl.sv
// Self-checking bench for pl_ddr_rd_ctrl: DataMover responder, output scoreboard
// and a chunking reference model computed from the transfer rules.
module tb_pl_ddr_rd_ctrl;

  localparam int CMD_W = 72;
`ifdef RD_STS_CHECK_EN
  localparam bit STS_ON = 1'b1;
`else
  localparam bit STS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ddr_init_done, rd_start, rd_busy, rd_done, rd_err, rd_valid, rd_ready, rd_last;
  logic [31:0] rd_addr, rd_len, rd_data, m_tdata;
  logic cmd_tvalid, cmd_tready, m_tvalid, m_tready, m_tlast, sts_tvalid, sts_tready;
  logic [CMD_W-1:0] cmd_tdata;
  logic [7:0] sts_tdata;

  pl_ddr_rd_ctrl #(.DATA_W(32), .ADDR_W(32), .CHUNK_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_init_done(ddr_init_done),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .s_axis_mm2s_cmd_tvalid(cmd_tvalid), .s_axis_mm2s_cmd_tready(cmd_tready),
    .s_axis_mm2s_cmd_tdata(cmd_tdata),
    .m_axis_mm2s_tvalid(m_tvalid), .m_axis_mm2s_tready(m_tready),
    .m_axis_mm2s_tlast(m_tlast), .m_axis_mm2s_tdata(m_tdata),
    .m_axis_mm2s_tkeep(4'hF),
    .m_axis_mm2s_sts_tvalid(sts_tvalid), .m_axis_mm2s_sts_tready(sts_tready),
    .m_axis_mm2s_sts_tdata(sts_tdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         beats;
    int         tlast_at;
    logic [7:0] sts;
  } item_t;

  item_t            work_q[$];
  logic [31:0]      src_q[$];
  logic [CMD_W-1:0] cmd_log[$];
  int cur_beat, chunk_idx, early_chunk, early_beats, sts_chunk;
  int out_beats, last_cnt, last_at, done_cnt;
  bit in_sts, m_hs, s_hs, bp, held;
  logic [7:0] sts_val;
  logic [CMD_W-1:0] held_data;
  logic [CMD_W-1:0] cmd_c;
  item_t it;

  // DataMover responder and output consumer: drive at negedge, evaluate handshakes at +1.
  initial begin
    rd_ready = 1'b1; cmd_tready = 1'b0; m_tvalid = 1'b0; m_tdata = 32'd0; m_tlast = 1'b0;
    sts_tvalid = 1'b0; sts_tdata = 8'd0;
    cur_beat = 0; in_sts = 1'b0; m_hs = 1'b0; s_hs = 1'b0; held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        work_q.delete(); src_q.delete();
        cur_beat = 0; in_sts = 1'b0; m_hs = 1'b0; s_hs = 1'b0; held = 1'b0;
        m_tvalid = 1'b0; m_tlast = 1'b0; sts_tvalid = 1'b0; cmd_tready = 1'b0;
      end else begin
        if (m_hs) begin
          m_tvalid = 1'b0;
          if (m_tlast) begin in_sts = 1'b1; cur_beat = 0; end
          else cur_beat++;
          m_tlast = 1'b0; m_hs = 1'b0;
        end
        if (s_hs) begin
          sts_tvalid = 1'b0; in_sts = 1'b0; work_q.delete(0); s_hs = 1'b0;
        end
        rd_ready   = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        cmd_tready = ($urandom_range(0, 3) != 0);
        if (work_q.size() > 0) begin
          if (in_sts) begin
            if (!sts_tvalid) begin sts_tvalid = 1'b1; sts_tdata = work_q[0].sts; end
          end else if (!m_tvalid && ($urandom_range(0, 3) != 0)) begin
            m_tvalid = 1'b1;
            m_tdata  = $urandom;
            m_tlast  = (cur_beat == work_q[0].tlast_at - 1);
          end
        end
        #1;
        if (held) begin
          check("cmd_hold_valid", 128'(cmd_tvalid), 128'(1));
          check("cmd_hold_data", 128'(cmd_tdata), 128'(held_data));
        end
        held = cmd_tvalid && !cmd_tready;
        held_data = cmd_tdata;
        if (cmd_tvalid && cmd_tready) begin
          cmd_c = cmd_tdata;
          cmd_log.push_back(cmd_c);
          it.beats    = int'(cmd_c[22:0]) / 4;
          it.tlast_at = (chunk_idx == early_chunk) ? early_beats : it.beats;
          it.sts      = (chunk_idx == sts_chunk) ? sts_val : 8'h80;
          work_q.push_back(it);
          chunk_idx++;
        end
        if (rd_valid && rd_ready) begin
          out_beats++;
          if (src_q.size() == 0) check("data_extra", 128'(1), 128'(0));
          else check("data", 128'(rd_data), 128'(src_q.pop_front()));
          if (rd_last) begin last_cnt++; last_at = out_beats; end
        end
        if (m_tvalid && m_tready) begin m_hs = 1'b1; src_q.push_back(m_tdata); end
        if (sts_tvalid && sts_tready) s_hs = 1'b1;
        if (rd_done) done_cnt++;
      end
    end
  end

  task automatic arm(input bit bpm, input int e_chunk, input int e_beats, input int s_chunk);
    bp = bpm; early_chunk = e_chunk; early_beats = e_beats; sts_chunk = s_chunk;
    sts_val = 8'h40; chunk_idx = 0; out_beats = 0; last_cnt = 0; last_at = 0;
    done_cnt = 0; cmd_log.delete();
  endtask

  task automatic run_xfer(input logic [31:0] addr, input logic [31:0] len, input bit bpm,
                          input int e_chunk, input int e_beats, input int s_chunk, input bit repulse);
    logic [CMD_W-1:0] exp_cmd[$];
    logic [31:0] a, rem, btt;
    logic [3:0] tag;
    int k, exp_beats;
    bit exp_err, sts_abort;
    a = addr; rem = len & 32'hFFFF_FFFC; tag = 4'd0; k = 0;
    exp_beats = 0; exp_err = 1'b0; sts_abort = 1'b0;
    while (rem != 32'd0) begin
      btt = (rem > 32'd4096) ? 32'd4096 : rem;
      exp_cmd.push_back({4'h0, tag, a, 1'b0, (rem <= 32'd4096), 6'h00, 1'b1, btt[22:0]});
      if (k == e_chunk) begin exp_beats += e_beats; exp_err = 1'b1; break; end
      exp_beats += int'(btt) / 4;
      if (STS_ON && k == s_chunk) begin exp_err = 1'b1; sts_abort = 1'b1; break; end
      a = a + btt; rem = rem - btt; tag = tag + 4'd1; k++;
    end

    @(negedge clk);
    arm(bpm, e_chunk, e_beats, s_chunk);
    rd_addr = addr; rd_len = len; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("start_busy", 128'(rd_busy), 128'(1));
    check("start_cmd_valid", 128'(cmd_tvalid), 128'(exp_cmd.size() > 0));
    for (int c = 0; c < 40000 && done_cnt == 0; c++) begin
      @(negedge clk);
      if (repulse && c == 20) begin
        rd_start = 1'b1; rd_addr = $urandom; rd_len = $urandom_range(4, 5000);
      end else begin
        rd_start = 1'b0;
      end
    end
    rd_start = 1'b0;
    check("done_seen", 128'(done_cnt != 0), 128'(1));
    for (int c = 0; c < 5000 && !(src_q.size() == 0 && work_q.size() == 0 && !rd_valid); c++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    check("drained", 128'(src_q.size() == 0 && work_q.size() == 0 && !rd_valid), 128'(1));
    check("done_count", 128'(done_cnt), 128'(1));
    check("cmd_count", 128'(cmd_log.size()), 128'(exp_cmd.size()));
    for (int i = 0; i < exp_cmd.size() && i < cmd_log.size(); i++)
      check("cmd_word", 128'(cmd_log[i]), 128'(exp_cmd[i]));
    check("beat_count", 128'(out_beats), 128'(exp_beats));
    check("err", 128'(rd_err), 128'(exp_err));
    check("busy_after", 128'(rd_busy), 128'(0));
    if (!sts_abort) begin
      check("last_count", 128'(last_cnt), 128'(exp_beats > 0));
      if (exp_beats > 0) check("last_pos", 128'(last_at), 128'(exp_beats));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 128'(rd_busy), 128'(0));
    check({tag, "_done"}, 128'(rd_done), 128'(0));
    check({tag, "_err"}, 128'(rd_err), 128'(0));
    check({tag, "_valid"}, 128'(rd_valid), 128'(0));
    check({tag, "_data"}, 128'(rd_data), 128'(0));
    check({tag, "_last"}, 128'(rd_last), 128'(0));
    check({tag, "_cmd_valid"}, 128'(cmd_tvalid), 128'(0));
    check({tag, "_cmd_data"}, 128'(cmd_tdata), 128'(0));
    check({tag, "_m_tready"}, 128'(m_tready), 128'(1));
    check({tag, "_sts_tready"}, 128'(sts_tready), 128'(!STS_ON));
  endtask

  initial begin
    rst_n = 1'b0; ddr_init_done = 1'b0; rd_start = 1'b0; rd_addr = 32'd0; rd_len = 32'd0;
    arm(1'b0, -1, 0, -1);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1'b1;

    // start while calibration is still pending must be ignored
    @(negedge clk);
    arm(1'b0, -1, 0, -1);
    rd_addr = 32'h1000; rd_len = 32'd64; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (10) @(negedge clk);
    check("init_gate_cmds", 128'(cmd_log.size()), 128'(0));
    check("init_gate_busy", 128'(rd_busy), 128'(0));
    check("init_gate_done", 128'(done_cnt), 128'(0));
    ddr_init_done = 1'b1;
    repeat (3) @(negedge clk);

    run_xfer(32'h0000_1000, 32'd64, 1'b0, -1, 0, -1, 1'b0);
    run_xfer(32'h0000_0000, 32'd10000, 1'b1, -1, 0, -1, 1'b1);
    run_xfer(32'hFFFF_F000, 32'd6002, 1'b1, -1, 0, -1, 1'b0);
    for (int r = 0; r < 3; r++)
      run_xfer($urandom & 32'hFFFF_FFFC, $urandom_range(0, 4500), 1'b1, -1, 0, -1, 1'b0);

    run_xfer(32'h0000_2000, 32'd64, 1'b0, 0, 5, -1, 1'b0);
    run_xfer(32'h0000_0000, 32'd10000, 1'b1, 1, 100, -1, 1'b0);
`ifdef RD_STS_CHECK_EN
    run_xfer(32'h0000_0000, 32'd10000, 1'b1, -1, 0, 0, 1'b0);
`endif
    run_xfer(32'h0000_3000, 32'd3, 1'b0, -1, 0, -1, 1'b0);

    // zero-length request: done two cycles after the start edge, no command
    @(negedge clk);
    arm(1'b0, -1, 0, -1);
    rd_len = 32'd0; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    check("len0_busy_n1", 128'(rd_busy), 128'(1));
    check("len0_done_n1", 128'(rd_done), 128'(0));
    check("len0_cmd_n1", 128'(cmd_tvalid), 128'(0));
    @(negedge clk);
    check("len0_done_n2", 128'(rd_done), 128'(1));
    check("len0_busy_n2", 128'(rd_busy), 128'(0));
    @(negedge clk);
    check("len0_done_n3", 128'(rd_done), 128'(0));
    check("len0_cmds", 128'(cmd_log.size()), 128'(0));

    run_xfer(32'h0000_0100, 32'd200, 1'b1, -1, 0, -1, 1'b0);

    // asynchronous reset in the middle of the data phase
    @(negedge clk);
    arm(1'b0, -1, 0, -1);
    rd_addr = 32'd0; rd_len = 32'd10000; rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    for (int c = 0; c < 4000 && out_beats < 10; c++) @(negedge clk);
    check("rst_reach_data", 128'(out_beats >= 10), 128'(1));
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    run_xfer(32'h0000_0040, 32'd128, 1'b1, -1, 0, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
